// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control definitions: FSM state codes, default widths and
// state decode helpers, reused by the debug unit.
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_SIZE_DEF   = 32;
  localparam int unsigned STATE_SIZE_DEF = 3;
  localparam int unsigned STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_WAIT_STEP = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Pipeline latches are clocked only while running or single-stepping.
  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

  // States in which a halt reaching WB terminates execution.
  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_WAIT_STEP);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Width-parameterised up-counter with enable, synchronous clear and
// saturation at all-ones (never wraps).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = (count == {WIDTH{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/halt controller for the five-stage pipeline: gates stage latches
// and PC updates, and counts enabled pipeline clocks.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_SIZE   = CNT_SIZE_DEF,
  parameter int unsigned STATE_SIZE = STATE_SIZE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic                  i_halt_id,
  input  logic                  i_halt_wb,
  input  logic                  i_stall,
  output logic                  o_pipe_enable,
  output logic                  o_pc_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [STATE_SIZE-1:0] o_state,
  output logic [CNT_SIZE-1:0]   o_cycle_count
);

  state_e state_q;
  state_e state_d;
  logic   done_q;
  logic   halt_fetched_q;
  logic   pipe_en;
  logic   cnt_clr;

  // State register plus the registered done pulse and halt-fetched flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      halt_fetched_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
      if (state_q == ST_IDLE) begin
        halt_fetched_q <= 1'b0;
      end else if (i_halt_id && pipe_en) begin
        halt_fetched_q <= 1'b1;
      end
    end
  end

  // Next-state logic; a halt in WB wins over every other request.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_halt_wb) begin
          state_d = ST_DONE;
        end
      end
      ST_STEP: begin
        state_d = i_halt_wb ? ST_DONE : ST_WAIT_STEP;
      end
      ST_WAIT_STEP: begin
        if (i_halt_wb) begin
          state_d = ST_DONE;
        end else if (i_run) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_DONE: begin
        if (i_clear) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore decode from the registered state only.
  assign pipe_en       = is_busy(state_q);
  assign o_pipe_enable = pipe_en;
  assign o_busy        = pipe_en;
  assign o_done        = done_q;
  assign o_state       = STATE_SIZE'(state_q);

  // Stalls and a fetched halt freeze the PC while latches keep moving.
  assign o_pc_enable = pipe_en && !halt_fetched_q && !i_stall;

  sat_counter #(
    .WIDTH (CNT_SIZE)
  ) u_cycle_cnt (
    .clk   (i_clk),
    .rst   (i_reset),
    .en    (pipe_en),
    .clr   (cnt_clr),
    .count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        run, step, clr, hid, hwb, stall;
  logic        pe, pc, busy, done;
  logic [2:0]  st;
  logic [31:0] cnt;
  logic        pe4, pc4, busy4, done4;
  logic [2:0]  st4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int     m_mode;   // 0 idle,1 run,2 step,3 wait,4 done
  bit     m_hf;
  longint m_cnt;
  bit     m_done;

  pipeline_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clr),
    .i_halt_id(hid), .i_halt_wb(hwb), .i_stall(stall),
    .o_pipe_enable(pe), .o_pc_enable(pc), .o_busy(busy), .o_done(done),
    .o_state(st), .o_cycle_count(cnt)
  );

  pipeline_ctrl #(.CNT_SIZE(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clr),
    .i_halt_id(hid), .i_halt_wb(hwb), .i_stall(stall),
    .o_pipe_enable(pe4), .o_pc_enable(pc4), .o_busy(busy4), .o_done(done4),
    .o_state(st4), .o_cycle_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit c, input bit hi,
                       input bit hw, input bit sl);
    run = r; step = s; clr = c; hid = hi; hwb = hw; stall = sl;
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_hf = 0; m_cnt = 0; m_done = 0;
  endtask

  // One clock of the specification's rules, using the inputs now applied.
  task automatic model_step();
    bit     en;
    int     nxt;
    en  = (m_mode == 1) || (m_mode == 2);
    nxt = m_mode;
    if (m_mode == 0)       nxt = run ? 1 : (step ? 2 : 0);
    else if (m_mode == 1)  nxt = hwb ? 4 : 1;
    else if (m_mode == 2)  nxt = hwb ? 4 : 3;
    else if (m_mode == 3)  nxt = hwb ? 4 : (run ? 1 : (step ? 2 : 3));
    else if (m_mode == 4)  nxt = clr ? 0 : 4;
    if (en && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_mode == 4 && nxt == 0) m_cnt = 0;
    if (m_mode == 0) m_hf = 0;
    else if (hid && en) m_hf = 1;
    m_done = (nxt == 4) && (m_mode != 4);
    m_mode = nxt;
  endtask

  task automatic clock();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    bit en;
    en = (m_mode == 1) || (m_mode == 2);
    chk({tag, ".state"}, st, m_mode);
    chk({tag, ".pipe_en"}, pe, en);
    chk({tag, ".busy"}, busy, en);
    chk({tag, ".pc_en"}, pc, en && !m_hf && !stall);
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".count"}, cnt, m_cnt);
    chk({tag, ".count4"}, cnt4, (m_cnt > 15) ? 15 : m_cnt);
    chk({tag, ".state4"}, st4, m_mode);
  endtask

  typedef struct {
    bit r, s, c, hi, hw, sl;
    int e_st;
    bit e_pe, e_pc, e_dn;
    int e_cnt;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(bit r, bit s, bit c, bit hi, bit hw, bit sl,
                              int e_st, bit e_pe, bit e_pc, bit e_dn, int e_cnt);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.hi = hi; v.hw = hw; v.sl = sl;
    v.e_st = e_st; v.e_pe = e_pe; v.e_pc = e_pc; v.e_dn = e_dn; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    int en_seen;
    //            r s c hi hw sl  st pe pc dn cnt
    tbl[0]  = mk(0,0,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(1,1,0,0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0, 1,1,1,0,0);
    tbl[3]  = mk(0,1,0,0,0,0, 1,1,1,0,1);
    tbl[4]  = mk(0,0,0,0,0,1, 1,1,0,0,2);
    tbl[5]  = mk(0,0,0,1,0,0, 1,1,1,0,3);
    tbl[6]  = mk(0,0,0,0,0,0, 1,1,0,0,4);
    tbl[7]  = mk(0,0,0,0,1,0, 1,1,0,0,5);
    tbl[8]  = mk(0,0,0,0,0,0, 4,0,0,1,6);
    tbl[9]  = mk(1,1,0,0,0,0, 4,0,0,0,6);
    tbl[10] = mk(0,0,0,0,1,0, 4,0,0,0,6);
    tbl[11] = mk(0,0,1,0,0,0, 4,0,0,0,6);
    tbl[12] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    tbl[13] = mk(0,1,0,0,0,0, 0,0,0,0,0);
    tbl[14] = mk(0,0,0,0,0,0, 2,1,1,0,0);
    tbl[15] = mk(0,0,0,0,0,0, 3,0,0,0,1);
    tbl[16] = mk(1,0,0,0,0,0, 3,0,0,0,1);
    tbl[17] = mk(0,0,0,0,0,0, 1,1,1,0,1);
    tbl[18] = mk(0,0,1,0,0,0, 1,1,1,0,2);
    tbl[19] = mk(0,0,0,0,1,0, 1,1,1,0,3);
    tbl[20] = mk(0,0,0,0,0,0, 4,0,0,1,4);
    tbl[21] = mk(0,0,1,0,0,0, 4,0,0,0,4);
    tbl[22] = mk(0,0,0,0,0,0, 0,0,0,0,0);

    // Reset state
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    rst = 1'b0;
    #1;

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].hi, tbl[i].hw, tbl[i].sl);
      chk($sformatf("tbl%0d.state", i), st, tbl[i].e_st);
      chk($sformatf("tbl%0d.pipe_en", i), pe, tbl[i].e_pe);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].e_pe);
      chk($sformatf("tbl%0d.pc_en", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.done", i), done, tbl[i].e_dn);
      chk($sformatf("tbl%0d.count", i), cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.count4", i), cnt4, tbl[i].e_cnt);
      clock();
    end

    // Run for 10 enabled cycles then halt in WB
    drive(1,0,0,0,0,0);
    clock();
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0,0,0,0, i == 9, 0);
      if (pe) en_seen++;
      check_model("run10");
      clock();
    end
    drive(0,0,0,0,0,0);
    chk("run10.enabled_cycles", en_seen, 10);
    chk("run10.count", cnt, 10);
    chk("run10.done", done, 1);
    chk("run10.state", st, 4);
    clock();
    chk("run10.done_pulse_end", done, 0);
    drive(0,0,1,0,0,0);
    clock();

    // Three single steps five cycles apart
    en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      drive(0,1,0,0,0,0);
      check_model("step");
      clock();
      for (int i = 0; i < 4; i++) begin
        drive(0,0,0,0,0,0);
        if (pe) en_seen++;
        if (i > 0) chk("step.wait_state", st, 3);
        check_model("step");
        clock();
      end
    end
    chk("step.enabled_cycles", en_seen, 3);
    chk("step.count", cnt, 3);
    drive(0,0,0,0,1,0);
    clock();
    drive(0,0,0,0,0,0);
    chk("step.halt_from_wait", st, 4);
    drive(0,0,1,0,0,0);
    clock();

    // Saturation of the narrow counter, then clear
    drive(1,0,0,0,0,0);
    clock();
    for (int i = 0; i < 20; i++) begin
      drive(0,0,0,0, i == 19, 0);
      check_model("sat");
      clock();
    end
    drive(0,0,0,0,0,0);
    chk("sat.count4", cnt4, 15);
    chk("sat.count", cnt, 20);
    drive(0,0,1,0,0,0);
    clock();
    drive(0,0,0,0,0,0);
    chk("sat.clear_state", st4, 0);
    chk("sat.clear_count4", cnt4, 0);
    chk("sat.clear_count", cnt, 0);

    // Asynchronous reset mid-run with count 7
    drive(1,0,0,0,0,0);
    clock();
    for (int i = 0; i < 7; i++) begin
      drive(0,0,0,0,0,0);
      clock();
    end
    drive(0,0,0,0,0,0);
    chk("areset.pre_count", cnt, 7);
    chk("areset.pre_state", st, 1);
    #1 rst = 1'b1;
    #1;
    chk("areset.pipe_en", pe, 0);
    chk("areset.pc_en", pc, 0);
    chk("areset.busy", busy, 0);
    chk("areset.done", done, 0);
    chk("areset.state", st, 0);
    chk("areset.count", cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model("areset.post");
    clock();
    check_model("areset.idle_hold");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
      check_model("rand");
      clock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
